// File: rtl/echo_multitap.sv
// echo_multitap: multi-tap echo built on a shared delay line in smart_ram.
// Each operation reads up to TAPS delayed samples, sums them after arithmetic
// right-shift attenuation, adds the dry input, saturates, and optionally
// writes dry or wet back to the delay line at wr_ptr.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   cs, my_turn           block select, start of a sample operation
//   should_save, feedback store this sample; store wet (1) or dry (0)
//   data_in, data_out     signed input sample, processed output sample
//   tap_delay, tap_shift  per-tap delay (slice k) and shift amount (slice k)
//   done                  one-cycle pulse when data_out is valid
//   sram_*                smart_ram request/response handshake
module echo_multitap #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned TAPS       = 4,
    parameter int unsigned OFFSET     = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cs,
    input  logic                         my_turn,
    input  logic                         should_save,
    input  logic                         feedback,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic [TAPS*ADDR_WIDTH-1:0]   tap_delay,
    input  logic [TAPS*4-1:0]            tap_shift,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         done,
    output logic                         sram_rd,
    output logic                         sram_wr,
    output logic [ADDR_WIDTH-1:0]        sram_offset,
    output logic signed [DATA_WIDTH-1:0] sram_data_out,
    input  logic signed [DATA_WIDTH-1:0] sram_data_in,
    input  logic                         sram_read_finish,
    input  logic                         sram_write_finish
);

    localparam int unsigned AccW = DATA_WIDTH + 4;
    localparam int unsigned IdxW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [ADDR_WIDTH-1:0] OffsetA = ADDR_WIDTH'(OFFSET);
    localparam logic signed [DATA_WIDTH-1:0] DataMax = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] DataMin = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [AccW:0] WetMax = {{6{1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [AccW:0] WetMin = {{6{1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StRead, StAcc, StSat, StWrite, StDone} state_e;

    state_e                       state_q;
    logic [IdxW-1:0]              tap_idx_q;
    logic signed [AccW-1:0]       acc_q;
    logic signed [DATA_WIDTH-1:0] din_q;
    logic signed [DATA_WIDTH-1:0] rd_data_q;
    logic                         save_q;
    logic                         fb_q;
    logic [ADDR_WIDTH-1:0]        wr_ptr_q;
    logic signed [DATA_WIDTH-1:0] data_out_q;
    logic signed [DATA_WIDTH-1:0] sram_data_out_q;
    logic                         done_q;
    logic                         sram_rd_q;
    logic                         sram_wr_q;
    logic [ADDR_WIDTH-1:0]        sram_offset_q;

    logic [ADDR_WIDTH-1:0]        first_delay;
    logic [ADDR_WIDTH-1:0]        nxt_delay;
    logic [3:0]                   cur_shift;
    logic                         last_tap;
    logic signed [DATA_WIDTH-1:0] shifted;
    logic signed [AccW-1:0]       acc_add;
    logic signed [AccW:0]         wet_full;
    logic signed [DATA_WIDTH-1:0] wet;

    // Tap selection and datapath arithmetic.
    always_comb begin
        first_delay = tap_delay[ADDR_WIDTH-1:0];
        nxt_delay   = '0;
        cur_shift   = '0;
        for (int k = 0; k < int'(TAPS); k++) begin
            if (IdxW'(k) == tap_idx_q) begin
                cur_shift = tap_shift[k*4 +: 4];
            end
            // Delay of the tap after the current one, used when advancing.
            if (k > 0 && IdxW'(k - 1) == tap_idx_q) begin
                nxt_delay = tap_delay[k*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
        last_tap = (tap_idx_q == IdxW'(TAPS - 1));
        shifted  = rd_data_q >>> cur_shift;
        acc_add  = {{4{shifted[DATA_WIDTH-1]}}, shifted};
        wet_full = {{5{din_q[DATA_WIDTH-1]}}, din_q} + {acc_q[AccW-1], acc_q};
        if (wet_full > WetMax) begin
            wet = DataMax;
        end else if (wet_full < WetMin) begin
            wet = DataMin;
        end else begin
            wet = wet_full[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= StIdle;
            tap_idx_q       <= '0;
            acc_q           <= '0;
            din_q           <= '0;
            rd_data_q       <= '0;
            save_q          <= 1'b0;
            fb_q            <= 1'b0;
            wr_ptr_q        <= '0;
            data_out_q      <= '0;
            sram_data_out_q <= '0;
            done_q          <= 1'b0;
            sram_rd_q       <= 1'b0;
            sram_wr_q       <= 1'b0;
            sram_offset_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q != StIdle && !cs) begin
                // Deselect aborts silently: no request, no done, pointers kept.
                state_q   <= StIdle;
                sram_rd_q <= 1'b0;
                sram_wr_q <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (cs && my_turn) begin
                            din_q         <= data_in;
                            save_q        <= should_save;
                            fb_q          <= feedback;
                            tap_idx_q     <= '0;
                            acc_q         <= '0;
                            sram_rd_q     <= (first_delay != '0);
                            sram_offset_q <= wr_ptr_q - first_delay + OffsetA;
                            state_q       <= StRead;
                        end
                    end
                    StRead: begin
                        if (!sram_rd_q) begin
                            // Zero-delay tap: no read, contributes nothing.
                            if (last_tap) begin
                                state_q <= StSat;
                            end else begin
                                tap_idx_q     <= tap_idx_q + IdxW'(1);
                                sram_rd_q     <= (nxt_delay != '0);
                                sram_offset_q <= wr_ptr_q - nxt_delay + OffsetA;
                            end
                        end else if (sram_read_finish) begin
                            sram_rd_q <= 1'b0;
                            rd_data_q <= sram_data_in;
                            state_q   <= StAcc;
                        end
                    end
                    StAcc: begin
                        acc_q <= acc_q + acc_add;
                        if (last_tap) begin
                            state_q <= StSat;
                        end else begin
                            tap_idx_q     <= tap_idx_q + IdxW'(1);
                            sram_rd_q     <= (nxt_delay != '0);
                            sram_offset_q <= wr_ptr_q - nxt_delay + OffsetA;
                            state_q       <= StRead;
                        end
                    end
                    StSat: begin
                        data_out_q <= wet;
                        if (save_q) begin
                            sram_wr_q       <= 1'b1;
                            sram_offset_q   <= wr_ptr_q + OffsetA;
                            sram_data_out_q <= fb_q ? wet : din_q;
                            state_q         <= StWrite;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                    StWrite: begin
                        if (sram_write_finish) begin
                            sram_wr_q <= 1'b0;
                            wr_ptr_q  <= wr_ptr_q + ADDR_WIDTH'(1);
                            done_q    <= 1'b1;
                            state_q   <= StDone;
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q   <= StIdle;
                        sram_rd_q <= 1'b0;
                        sram_wr_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_out      = data_out_q;
    assign done          = done_q;
    assign sram_rd       = sram_rd_q;
    assign sram_wr       = sram_wr_q;
    assign sram_offset   = sram_offset_q;
    assign sram_data_out = sram_data_out_q;

endmodule

// File: doc/echo_multitap.md
ECHO_MULTITAP -- requirements
Module: echo_multitap

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- DATA_WIDTH, 16, signed sample width
- ADDR_WIDTH, 12, delay-line address width; line depth is 2^ADDR_WIDTH
- TAPS, 4, number of echo taps (1..8)
- OFFSET, 0, base address of the delay line in smart_ram
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge
- rst, in, 1, asynchronous active-low reset
- cs, in, 1, block selected
- my_turn, in, 1, sample slot granted; start of a sample operation
- should_save, in, 1, write this sample into the delay line
- feedback, in, 1, 1 = store wet output; 0 = store dry input
- data_in, in, DATA_WIDTH, input sample (signed)
- tap_delay, in, TAPS*ADDR_WIDTH, delay of tap k in samples, in slice k
- tap_shift, in, TAPS*4, arithmetic right-shift attenuation of tap k, in slice k
- data_out, out, DATA_WIDTH, processed sample (signed)
- done, out, 1, one-cycle pulse when data_out is valid
- sram_rd, out, 1, smart_ram read request
- sram_wr, out, 1, smart_ram write request
- sram_offset, out, ADDR_WIDTH, smart_ram address
- sram_data_out, out, DATA_WIDTH, write data to smart_ram
- sram_data_in, in, DATA_WIDTH, read data from smart_ram
- sram_read_finish, in, 1, read complete; sram_data_in valid this cycle
- sram_write_finish, in, 1, write complete

Function
REQ-003 FSM states SHALL be IDLE, READ, ACC, SAT, WRITE, DONE.
REQ-004 IDLE -> READ SHALL occur when cs=1 and my_turn=1; data_in, should_save and feedback are latched that cycle, and the tap index and accumulator are cleared.
REQ-005 In READ for tap k, sram_offset SHALL equal (wr_ptr - tap_delay[k]) mod 2^ADDR_WIDTH + OFFSET (mod 2^ADDR_WIDTH).
- sram_rd is held at 1 until the cycle sram_read_finish=1.
- The FSM then goes to ACC.
REQ-006 A tap with tap_delay[k]=0 SHALL be skipped: no read is issued and the tap contributes 0.
REQ-007 ACC SHALL add (sram_data_in >>> tap_shift[k]), sign-extended, to an accumulator of width DATA_WIDTH+4.
- If taps remain, the index increments and the FSM returns to READ.
- After the last tap, the FSM goes to SAT.
REQ-008 SAT SHALL compute wet = latched data_in + accumulator, saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], and register it as data_out.
- With should_save=1, the FSM goes to WRITE; otherwise it goes to DONE.
REQ-009 WRITE SHALL drive sram_offset = wr_ptr + OFFSET and sram_data_out = (feedback ? wet : dry).
- sram_wr is held at 1 until sram_write_finish=1.
- wr_ptr then increments, wrapping from 2^ADDR_WIDTH-1 to 0.
- The FSM then goes to DONE.
REQ-010 DONE SHALL assert done for exactly one cycle, then go to IDLE.
- A new operation requires my_turn to be sampled again in IDLE.
REQ-011 sram_rd and sram_wr SHALL never be 1 in the same cycle, and both SHALL be 0 outside READ and WRITE.
REQ-012 If cs falls in any non-IDLE state, the FSM SHALL return to IDLE next cycle.
- No write is issued and done is not asserted.
- data_out and wr_ptr are unchanged.
REQ-013 data_out SHALL hold its last value between operations.
REQ-014 With should_save=0, wr_ptr SHALL remain unchanged.
REQ-015 A read_finish or write_finish pulse arriving outside the matching state SHALL be ignored.

Reset
REQ-016 While rst=0, the block SHALL asynchronously force state=IDLE, wr_ptr=0, accumulator=0, data_out=0, done=0, sram_rd=0, sram_wr=0, sram_offset=0 and sram_data_out=0.
REQ-017 rst asserted mid-operation SHALL abort the operation with no further smart_ram request.
REQ-018 After rst releases, the first operation SHALL start only on a fresh cs=1 and my_turn=1 sampled in IDLE.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Single tap, wr_ptr=3, tap_delay=3, shift 0, mem[0]=100, data_in=50, should_save=1, feedback=0 -> reads offset 0, data_out=150, writes 50 at offset 3, wr_ptr=4, one done pulse.
- TAPS=4, delays 1/2/0/4, shifts 0/1/0/2, mem values 40/80/x/160, data_in=10 -> three reads, tap 3 skipped, data_out=10+40+40+40=130.
- Saturation: data_in=32000, tap value 32000 -> data_out=32767; data_in=-32000, tap value -32000 -> data_out=-32768.
- Feedback=1, should_save=1 -> sram_data_out equals the saturated wet value; wr_ptr at 4095 wraps to 0 after the write.
- cs dropped during the second READ -> return to IDLE, no sram_wr, no done, wr_ptr unchanged; rst=0 pulse during WRITE -> all outputs zero immediately.
- should_save=0 with a stalled read_finish held off 10 cycles -> sram_rd stays high 10 cycles, done fires, no write.
